// File: rtl/datamem_arbiter_pkg.sv
// Shared types and default sizes for the data-memory arbiter.
// Imported by the interface, the round-robin picker and the top level.
package datamem_arbiter_pkg;

  localparam int ADDR_W_DEF  = 11;
  localparam int DATA_W_DEF  = 256;
  localparam int MEM_LAT_DEF = 2;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef logic             port_id_t;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/datamem_arbiter_if.sv
// Requester and memory-side bundle of the data-memory arbiter.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface datamem_arbiter_if
  import datamem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              p0_req,   p1_req;
  logic              p0_we,    p1_we;
  logic [ADDR_W-1:0] p0_addr,  p1_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata;
  logic              p0_ack,   p1_ack;
  logic [DATA_W-1:0] p0_rdata, p1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata, mem_rdata,
    output p0_ack, p1_ack, p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_read, mem_write, busy
  );

  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata, mem_rdata,
    input  p0_ack, p1_ack, p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_read, mem_write, busy
  );
endinterface

// File: rtl/datamem_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick: a lone request wins outright,
// a tie goes to the port that was not granted last.
module rr_arbiter2
  import datamem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   last_grant,
  output port_id_t   grant_id,
  output logic       grant_valid
);

  always_comb begin
    grant_valid = |req;
    grant_id    = 1'b0;
    case (req)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/datamem_arbiter.sv
// Shares one data memory between two requesters: round-robin grant in IDLE,
// MEM_LAT cycles of memory access, then a one-cycle ack with registered read data.
module datamem_arbiter
  import datamem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF
)(
  input logic             clock,
  input logic             reset,
  datamem_arbiter_if.slave bus
);

  localparam cnt_t CNT_LAST = cnt_t'(MEM_LAT - 1);

  state_e            state_q,     state_d;
  cnt_t              cnt_q,       cnt_d;
  port_id_t          last_grant_q, last_grant_d;
  port_id_t          port_q,      port_d;
  logic              we_q,        we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_read_q,  mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              busy_q,      busy_d;
  logic              p0_ack_q,    p0_ack_d;
  logic              p1_ack_q,    p1_ack_d;
  logic [DATA_W-1:0] p0_rdata_q,  p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q,  p1_rdata_d;

  logic [1:0] req;
  port_id_t   grant_id;
  logic       grant_valid;

  assign req = {bus.p1_req, bus.p0_req};

  rr_arbiter2 u_rr (
    .req         (req),
    .last_grant  (last_grant_q),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  // Memory outputs are registered from the next state, so the address/data
  // latch doubles as the value held on the bus in IDLE and RESP.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    we_d         = we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    p0_ack_d     = 1'b0;
    p1_ack_d     = 1'b0;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d      = ST_ACCESS;
          cnt_d        = '0;
          port_d       = grant_id;
          last_grant_d = grant_id;
          if (grant_id == 1'b1) begin
            we_d        = bus.p1_we;
            mem_addr_d  = bus.p1_addr;
            mem_wdata_d = bus.p1_wdata;
          end else begin
            we_d        = bus.p0_we;
            mem_addr_d  = bus.p0_addr;
            mem_wdata_d = bus.p0_wdata;
          end
          mem_read_d  = ~we_d;
          mem_write_d = we_d;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q + cnt_t'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RESP;
          if (port_q == 1'b1) begin
            p1_ack_d = 1'b1;
            if (!we_q) p1_rdata_d = bus.mem_rdata;
          end else begin
            p0_ack_d = 1'b1;
            if (!we_q) p0_rdata_d = bus.mem_rdata;
          end
        end else begin
          state_d    = ST_ACCESS;
          mem_read_d = ~we_q;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      busy_q       <= 1'b0;
      p0_ack_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      we_q         <= we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      busy_q       <= busy_d;
      p0_ack_q     <= p0_ack_d;
      p1_ack_q     <= p1_ack_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
    end
  end

  assign bus.p0_ack    = p0_ack_q;
  assign bus.p1_ack    = p1_ack_q;
  assign bus.p0_rdata  = p0_rdata_q;
  assign bus.p1_rdata  = p1_rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Self-checking bench for datamem_arbiter: directed scenarios plus a randomized
// two-port stream checked against a reference memory and per-port read-data model.
module tb_datamem_arbiter;
  import datamem_arbiter_pkg::*;

  localparam int AW  = 11;
  localparam int DW  = 256;
  localparam int LAT = 2;
  localparam logic [DW-1:0] JUNK = {8{32'hDEAD_BEEF}};

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [DW-1:0] mem     [2048];
  logic [DW-1:0] ref_mem [2048];

  datamem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus  ();
  datamem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  datamem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clock (clock), .reset (reset), .bus (bus.slave));
  datamem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut1 (
    .clock (clock), .reset (reset), .bus (bus1.slave));

  always #5 clock = ~clock;

  // Memory model: combinational read while strobed, write on the clock edge.
  assign bus.mem_rdata  = bus.mem_read  ? mem[bus.mem_addr]  : JUNK;
  assign bus1.mem_rdata = bus1.mem_read ? mem[bus1.mem_addr] : JUNK;
  always @(posedge clock) begin
    if (bus.mem_write)  mem[bus.mem_addr]  <= bus.mem_wdata;
    if (bus1.mem_write) mem[bus1.mem_addr] <= bus1.mem_wdata;
  end

  function automatic logic [DW-1:0] rand_blk();
    logic [DW-1:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive(input int p, input logic req, input logic we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    if (p == 0) begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wd;
    end else begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wd;
    end
  endtask

  // Cycles are counted with the cycle that raises req as cycle 1.
  task automatic wait_ack(input int port, input int budget, output int cyc, output logic got,
                          output int rd_n, output int wr_n, output logic other,
                          output logic [AW-1:0] waddr);
    cyc = 1; got = 1'b0; rd_n = 0; wr_n = 0; other = 1'b0; waddr = '0;
    while (!got && cyc < budget) begin
      @(negedge clock);
      cyc++;
      if (bus.mem_read) rd_n++;
      if (bus.mem_write) begin wr_n++; waddr = bus.mem_addr; end
      got = (port == 0) ? bus.p0_ack : bus.p1_ack;
      if ((port == 0) ? bus.p1_ack : bus.p0_ack) other = 1'b1;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++; if (bus.p0_ack !== 1'b0 || bus.p1_ack !== 1'b0) begin failures++; $display("FAIL reset_acks: got %b%b want 00", bus.p1_ack, bus.p0_ack); end
    checks++; if (bus.p0_rdata !== '0 || bus.p1_rdata !== '0) begin failures++; $display("FAIL reset_rdata: got %0h/%0h want 0", bus.p0_rdata, bus.p1_rdata); end
    checks++; if (bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin failures++; $display("FAIL reset_mem_bus: got %0h/%0h want 0", bus.mem_addr, bus.mem_wdata); end
    checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL reset_strobes: got r%b w%b b%b want 000", bus.mem_read, bus.mem_write, bus.busy); end
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    int cyc, rd_n, wr_n; logic got, other; logic [AW-1:0] wa; int acks;
    @(negedge clock); drive(0, 1'b1, 1'b0, 11'h003, '0);
    @(negedge clock); @(negedge clock);
    checks++; if (bus.busy !== 1'b1 || bus.mem_read !== 1'b1) begin failures++; $display("FAIL mid_access_busy: got b%b r%b want 11", bus.busy, bus.mem_read); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_addr !== '0 || bus.p0_ack !== 1'b0) begin failures++; $display("FAIL async_reset_outputs: got b%b r%b a%0h k%b want 0", bus.busy, bus.mem_read, bus.mem_addr, bus.p0_ack); end
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clock); reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (bus.p0_ack || bus.p1_ack || bus.busy) acks++;
    end
    checks++; if (acks != 0) begin failures++; $display("FAIL no_ack_after_reset: got %0d active cycles want 0", acks); end
    drive(0, 1'b1, 1'b0, 11'h009, '0);
    wait_ack(0, 20, cyc, got, rd_n, wr_n, other, wa);
    drive(0, 1'b0, 1'b0, '0, '0);
    checks++; if (!got || bus.p0_rdata !== ref_mem[9]) begin failures++; $display("FAIL post_reset_read: got ack%b %0h want %0h", got, bus.p0_rdata, ref_mem[9]); end
  endtask

  task automatic test_single_read();
    int cyc, rd_n, wr_n; logic got, other; logic [AW-1:0] wa;
    @(negedge clock); drive(0, 1'b1, 1'b0, 11'h005, '0);
    wait_ack(0, 20, cyc, got, rd_n, wr_n, other, wa);
    drive(0, 1'b0, 1'b0, '0, '0);
    checks++; if (!got || cyc != LAT + 2) begin failures++; $display("FAIL read_latency: got %0d (ack %b) want %0d", cyc, got, LAT + 2); end
    checks++; if (rd_n != LAT || wr_n != 0) begin failures++; $display("FAIL read_strobes: got rd%0d wr%0d want rd%0d wr0", rd_n, wr_n, LAT); end
    checks++; if (bus.p0_rdata !== {32{8'hA5}}) begin failures++; $display("FAIL read_data: got %0h want a5..a5", bus.p0_rdata); end
    checks++; if (other) begin failures++; $display("FAIL read_other_ack: got 1 want 0"); end
  endtask

  task automatic test_single_write();
    int cyc, rd_n, wr_n; logic got, other; logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    wd = {16{16'h1234}};
    @(negedge clock); drive(1, 1'b1, 1'b1, 11'h7FF, wd);
    wait_ack(1, 20, cyc, got, rd_n, wr_n, other, wa);
    drive(1, 1'b0, 1'b0, '0, '0);
    ref_mem[11'h7FF] = wd;
    checks++; if (!got || cyc != LAT + 2) begin failures++; $display("FAIL write_latency: got %0d (ack %b) want %0d", cyc, got, LAT + 2); end
    checks++; if (wr_n != 1 || wa !== 11'h7FF || rd_n != 0) begin failures++; $display("FAIL write_strobe: got wr%0d addr %0h rd%0d want wr1 addr 7ff rd0", wr_n, wa, rd_n); end
    checks++; if (bus.p1_rdata !== '0) begin failures++; $display("FAIL write_rdata_held: got %0h want 0", bus.p1_rdata); end
    @(negedge clock); drive(0, 1'b1, 1'b0, 11'h7FF, '0);
    wait_ack(0, 20, cyc, got, rd_n, wr_n, other, wa);
    drive(0, 1'b0, 1'b0, '0, '0);
    checks++; if (!got || bus.p0_rdata !== wd) begin failures++; $display("FAIL write_readback: got %0h want %0h", bus.p0_rdata, wd); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a [2];
    int k, cyc;
    pulse_reset();
    a[0] = AW'($urandom_range(0, 2047)); a[1] = AW'($urandom_range(0, 2047));
    drive(0, 1'b1, 1'b0, a[0], '0); drive(1, 1'b1, 1'b0, a[1], '0);
    k = 0; cyc = 1;
    while (k < 8 && cyc < 60) begin
      @(negedge clock); cyc++;
      if (bus.p0_ack || bus.p1_ack) begin
        int p;
        p = bus.p1_ack ? 1 : 0;
        checks++;
        if ((bus.p0_ack && bus.p1_ack) || p != (k % 2) || cyc != 4 * (k + 1) ||
            (p == 0 ? bus.p0_rdata : bus.p1_rdata) !== ref_mem[a[p]]) begin
          failures++;
          $display("FAIL rr_ack_%0d: got port %0d cycle %0d want port %0d cycle %0d", k, p, cyc, k % 2, 4 * (k + 1));
        end
        a[p] = AW'($urandom_range(0, 2047));
        drive(p, 1'b1, 1'b0, a[p], '0);
        k++;
      end
    end
    drive(0, 1'b0, 1'b0, '0, '0); drive(1, 1'b0, 1'b0, '0, '0);
    checks++; if (k != 8) begin failures++; $display("FAIL rr_timeout: got %0d acks want 8", k); end
  endtask

  task automatic test_held_off();
    int cyc, ack0, ack1, idle_n;
    @(negedge clock); @(negedge clock);
    drive(0, 1'b1, 1'b0, 11'h020, '0);
    @(negedge clock); drive(1, 1'b1, 1'b0, 11'h021, '0);
    cyc = 2; ack0 = 0; ack1 = 0; idle_n = 0;
    while (ack1 == 0 && cyc < 30) begin
      @(negedge clock); cyc++;
      if (!bus.busy) idle_n++;
      if (bus.p0_ack) begin ack0 = cyc; drive(0, 1'b0, 1'b0, '0, '0); end
      if (bus.p1_ack) begin
        ack1 = cyc;
        checks++; if (bus.p1_rdata !== ref_mem[11'h021]) begin failures++; $display("FAIL held_off_data: got %0h want %0h", bus.p1_rdata, ref_mem[11'h021]); end
        drive(1, 1'b0, 1'b0, '0, '0);
      end
    end
    checks++; if (ack0 != LAT + 2 || ack1 != 2 * (LAT + 2)) begin failures++; $display("FAIL held_off_timing: got ack0@%0d ack1@%0d want %0d/%0d", ack0, ack1, LAT + 2, 2 * (LAT + 2)); end
    checks++; if (idle_n != 1) begin failures++; $display("FAIL held_off_busy: got %0d idle cycles want 1", idle_n); end
  endtask

  task automatic test_random();
    logic          pend [2];
    logic          w    [2];
    logic [AW-1:0] a    [2];
    logic [DW-1:0] d    [2];
    logic [DW-1:0] last_rd [2];
    int gap [2]; int age [2];
    int issued, done, cyc, bad;
    pulse_reset();
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; gap[p] = 0; age[p] = 0; last_rd[p] = '0;
      w[p] = 1'b0; a[p] = '0; d[p] = '0;
    end
    issued = 0; done = 0; cyc = 0; bad = 0;
    while ((done < 40 || pend[0] || pend[1]) && cyc < 3000) begin
      @(negedge clock); cyc++;
      if (bus.p0_ack && bus.p1_ack) bad++;
      for (int p = 0; p < 2; p++) begin
        logic ack; logic [DW-1:0] rd;
        ack = (p == 0) ? bus.p0_ack : bus.p1_ack;
        rd  = (p == 0) ? bus.p0_rdata : bus.p1_rdata;
        if (ack && !pend[p]) bad++;
        if (pend[p]) begin
          age[p]++;
          if (ack) begin
            if (w[p]) ref_mem[a[p]] = d[p];
            else      last_rd[p] = ref_mem[a[p]];
            checks++;
            if (rd !== last_rd[p] || age[p] > 2 * LAT + 4) begin
              failures++;
              $display("FAIL rand_p%0d_%s_%0h: got %0h age %0d want %0h age<=%0d", p, w[p] ? "wr" : "rd", a[p], rd, age[p], last_rd[p], 2 * LAT + 4);
            end
            pend[p] = 1'b0; done++;
            gap[p] = $urandom_range(0, 3);
            drive(p, 1'b0, 1'b0, '0, '0);
          end
        end else if (gap[p] > 0) begin
          gap[p]--;
        end else if (issued < 40) begin
          w[p] = 1'($urandom_range(0, 1)); a[p] = AW'($urandom_range(0, 15)); d[p] = rand_blk();
          pend[p] = 1'b1; age[p] = 1; issued++;
          drive(p, 1'b1, w[p], a[p], d[p]);
        end
      end
    end
    checks++; if (done != 40 || bad != 0) begin failures++; $display("FAIL rand_stream: got %0d done %0d protocol errors want 40/0", done, bad); end
  endtask

  task automatic test_mem_lat1();
    int cyc, rd_n; logic got;
    logic [AW-1:0] ad; logic [DW-1:0] wd;
    ad = AW'($urandom_range(16, 2047)); wd = rand_blk();
    @(negedge clock);
    bus1.p0_req = 1'b1; bus1.p0_we = 1'b1; bus1.p0_addr = ad; bus1.p0_wdata = wd;
    cyc = 1; got = 1'b0;
    while (!got && cyc < 20) begin @(negedge clock); cyc++; got = bus1.p0_ack; end
    bus1.p0_req = 1'b0; bus1.p0_we = 1'b0;
    ref_mem[ad] = wd;
    checks++; if (!got || cyc != 3) begin failures++; $display("FAIL lat1_write: got %0d want 3", cyc); end
    @(negedge clock); bus1.p0_req = 1'b1;
    cyc = 1; got = 1'b0; rd_n = 0;
    while (!got && cyc < 20) begin
      @(negedge clock); cyc++;
      if (bus1.mem_read) rd_n++;
      got = bus1.p0_ack;
    end
    bus1.p0_req = 1'b0;
    checks++; if (!got || cyc != 3 || rd_n != 1) begin failures++; $display("FAIL lat1_read_timing: got cycle %0d rd%0d want 3 rd1", cyc, rd_n); end
    checks++; if (bus1.p0_rdata !== ref_mem[ad]) begin failures++; $display("FAIL lat1_read_data: got %0h want %0h", bus1.p0_rdata, ref_mem[ad]); end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem[i] = {8{16'(i), 16'hC0DE}};
      ref_mem[i] = mem[i];
    end
    mem[5] = {32{8'hA5}}; ref_mem[5] = mem[5];
    drive(0, 1'b0, 1'b0, '0, '0); drive(1, 1'b0, 1'b0, '0, '0);
    bus1.p0_req = 1'b0; bus1.p0_we = 1'b0; bus1.p0_addr = '0; bus1.p0_wdata = '0;
    bus1.p1_req = 1'b0; bus1.p1_we = 1'b0; bus1.p1_addr = '0; bus1.p1_wdata = '0;
    test_reset();
    test_reset_mid_access();
    test_single_read();
    test_single_write();
    test_back_to_back();
    test_held_off();
    test_random();
    test_mem_lat1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
